// File: rtl/ex_mdu_stage.sv
// Execute stage between id_ex and ex_mem: single-cycle ALU pass-through, iterative
// restoring divide/modulo (holds the stage), and DATA_W-generic store lane/misalign logic.
module ex_mdu_stage #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic              mem_allowin_i,
  input  logic              mem_stall_i,
  input  logic              excep_flush_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] oper1_i,
  input  logic [DATA_W-1:0] oper2_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [1:0]        st_size_i,
  input  logic              excep_en_i,
  output logic              ex_allowin_o,
  output logic              ex_to_mem_valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [BE_W-1:0]   mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              excep_en_o,
  output logic              ale_o,
  output logic              div_busy_o
);

  localparam int OFF_W = $clog2(BE_W);
  localparam logic [2:0] OP_DIV   = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_MOD   = 3'd3;
  localparam logic [2:0] OP_MODU  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] dvs_r;
  logic              neg_q_r;
  logic              neg_r_r;

  logic              is_div_s;
  logic              is_signed_s;
  logic              is_mod_s;
  logic              is_store_s;
  logic              start_s;
  logic              s1_s;
  logic              s2_s;
  logic [DATA_W-1:0] abs1_s;
  logic [DATA_W-1:0] abs2_s;
  logic [DATA_W:0]   shift_s;
  logic [DATA_W:0]   trial_s;
  logic              q_bit_s;
  logic [DATA_W-1:0] rem_nxt_s;
  logic [DATA_W-1:0] quo_nxt_s;
  logic [DATA_W-1:0] quo_fix_s;
  logic [DATA_W-1:0] rem_fix_s;
  logic [7:0]        base8_s;
  logic              misal_s;
  logic [BE_W-1:0]   mask_s;
  logic [DATA_W-1:0] wdata_s;
  logic [OFF_W-1:0]  off_s;
  logic              store_ok_s;
  logic              ale_s;
  logic              excep_s;
  logic              ready_go_s;
  logic              to_mem_s;
  logic [DATA_W-1:0] result_s;

  assign is_div_s    = (op_i == OP_DIV) || (op_i == OP_DIVU) || (op_i == OP_MOD) || (op_i == OP_MODU);
  assign is_signed_s = (op_i == OP_DIV) || (op_i == OP_MOD);
  assign is_mod_s    = (op_i == OP_MOD) || (op_i == OP_MODU);
  assign is_store_s  = (op_i == OP_STORE);
  assign start_s     = ex_valid_i & is_div_s & ~excep_flush_i & ~excep_en_i;

  assign s1_s   = is_signed_s & oper1_i[DATA_W-1];
  assign s2_s   = is_signed_s & oper2_i[DATA_W-1];
  assign abs1_s = s1_s ? -oper1_i : oper1_i;
  assign abs2_s = s2_s ? -oper2_i : oper2_i;

  // One restoring step plus final sign/zero-divisor fixup applied on the last step
  always_comb begin
    shift_s   = {rem_r, quo_r[DATA_W-1]};
    trial_s   = shift_s - {1'b0, dvs_r};
    q_bit_s   = ~trial_s[DATA_W];
    rem_nxt_s = q_bit_s ? trial_s[DATA_W-1:0] : shift_s[DATA_W-1:0];
    quo_nxt_s = {quo_r[DATA_W-2:0], q_bit_s};
    if (dvs_r == {DATA_W{1'b0}}) begin
      quo_fix_s = {DATA_W{1'b1}};
    end else if (neg_q_r) begin
      quo_fix_s = -quo_nxt_s;
    end else begin
      quo_fix_s = quo_nxt_s;
    end
    rem_fix_s = neg_r_r ? -rem_nxt_s : rem_nxt_s;
  end

  // Divider FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) state_nxt_s = S_DIV;
        else         state_nxt_s = S_IDLE;
      end
      S_DIV: begin
        if (excep_flush_i)          state_nxt_s = S_IDLE;
        else if (cnt_r == CNT_LAST) state_nxt_s = S_DONE;
        else                        state_nxt_s = S_DIV;
      end
      S_DONE: begin
        if (excep_flush_i)                 state_nxt_s = S_IDLE;
        else if (to_mem_s & mem_allowin_i) state_nxt_s = S_IDLE;
        else                               state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Divider FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Divider datapath: operand latch on start, shift/subtract while iterating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      quo_r   <= {DATA_W{1'b0}};
      rem_r   <= {DATA_W{1'b0}};
      dvs_r   <= {DATA_W{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            quo_r   <= abs1_s;
            rem_r   <= {DATA_W{1'b0}};
            dvs_r   <= abs2_s;
            neg_q_r <= s1_s ^ s2_s;
            neg_r_r <= s1_s;
          end
        end
        S_DIV: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            quo_r <= quo_fix_s;
            rem_r <= rem_fix_s;
          end else begin
            quo_r <= quo_nxt_s;
            rem_r <= rem_nxt_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign off_s = oper1_i[OFF_W-1:0];

  // Store byte-lane mask, lane-replicated data and alignment check
  always_comb begin
    base8_s = 8'h00;
    misal_s = 1'b0;
    wdata_s = oper2_i;
    case (st_size_i)
      2'd0: begin
        base8_s = 8'h01;
        wdata_s = {BE_W{oper2_i[7:0]}};
      end
      2'd1: begin
        base8_s = 8'h03;
        misal_s = oper1_i[0];
        wdata_s = {(DATA_W/16){oper2_i[15:0]}};
      end
      2'd2: begin
        base8_s = 8'h0F;
        misal_s = (oper1_i[1:0] != 2'b00);
        wdata_s = {(DATA_W/32){oper2_i[31:0]}};
      end
      2'd3: begin
        base8_s = 8'hFF;
        misal_s = (DATA_W == 32) || (oper1_i[2:0] != 3'b000);
        wdata_s = oper2_i;
      end
      default: begin
        base8_s = 8'h00;
        misal_s = 1'b0;
      end
    endcase
    mask_s = BE_W'(base8_s) << off_s;
  end

  assign store_ok_s = ex_valid_i & is_store_s;
  assign ale_s      = store_ok_s & misal_s;
  assign excep_s    = (excep_en_i | ale_s) & ex_valid_i;
  // An excepting divide never starts, so it must not wait for DONE
  assign ready_go_s = ~mem_stall_i & (~is_div_s | (state_r == S_DONE) | excep_s);
  assign to_mem_s   = ex_valid_i & ready_go_s;

  // Register write data selection
  always_comb begin
    result_s = {DATA_W{1'b0}};
    if (!ex_valid_i) begin
      result_s = {DATA_W{1'b0}};
    end else if (is_div_s) begin
      if (state_r == S_DONE) result_s = is_mod_s ? rem_r : quo_r;
      else                   result_s = {DATA_W{1'b0}};
    end else begin
      result_s = alu_res_i;
    end
  end

  assign ex_allowin_o      = ~ex_valid_i | (ready_go_s & mem_allowin_i);
  assign ex_to_mem_valid_o = to_mem_s;
  assign result_o          = result_s;
  assign mem_we_o          = (store_ok_s & ~excep_flush_i & ~mem_stall_i & ~excep_s) ? mask_s : {BE_W{1'b0}};
  assign mem_addr_o        = store_ok_s ? oper1_i : {DATA_W{1'b0}};
  assign mem_wdata_o       = store_ok_s ? wdata_s : {DATA_W{1'b0}};
  assign excep_en_o        = excep_s;
  assign ale_o             = ale_s;
  assign div_busy_o        = (state_r == S_DIV);

endmodule
